// File: rtl/tcp_tx_packet_generator.sv
// tcp_tx_packet_generator: builds outbound TCP segments (IP header request, TCP header + options, payload)
// with the TCP checksum summed one 16-bit word per cycle before the header is sent.
module tcp_tx_packet_generator #(
  parameter int OPT_WORDS_MAX = 2,
  parameter int IP_TTL = 64,
  localparam int OW = $clog2(OPT_WORDS_MAX + 1)
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_hdr_valid,
  output logic                       o_hdr_ready,
  input  logic [31:0]                i_src_ip,
  input  logic [31:0]                i_dst_ip,
  input  logic [15:0]                i_source_port,
  input  logic [15:0]                i_dest_port,
  input  logic [31:0]                i_seq_number,
  input  logic [31:0]                i_ack_number,
  input  logic [7:0]                 i_flags,
  input  logic [15:0]                i_window_size,
  input  logic [OW-1:0]              i_opt_words,
  input  logic [32*OPT_WORDS_MAX-1:0] i_options,
  input  logic [15:0]                i_payload_len,
  input  logic [15:0]                i_payload_sum,
  input  logic [7:0]                 s_axis_data_tdata,
  input  logic                       s_axis_data_tvalid,
  output logic                       s_axis_data_tready,
  input  logic                       s_axis_data_tlast,
  output logic                       m_ip_hdr_valid,
  input  logic                       m_ip_hdr_ready,
  output logic [5:0]                 m_ip_dscp,
  output logic [1:0]                 m_ip_ecn,
  output logic [15:0]                m_ip_length,
  output logic [7:0]                 m_ip_ttl,
  output logic [7:0]                 m_ip_protocol,
  output logic [31:0]                m_ip_source_ip,
  output logic [31:0]                m_ip_dest_ip,
  output logic [7:0]                 m_ip_payload_axis_tdata,
  output logic                       m_ip_payload_axis_tvalid,
  input  logic                       m_ip_payload_axis_tready,
  output logic                       m_ip_payload_axis_tlast,
  output logic                       m_ip_payload_axis_tuser,
  output logic                       o_packet_done,
  output logic                       o_error
);
  localparam int HB = 20 + 4 * OPT_WORDS_MAX;
  localparam int IW = $clog2(HB);
  typedef enum logic [2:0] {IDLE, SUM, FOLD, IPHDR, HDR, DATA, DRAIN} state_t;
  state_t state, state_n;
  logic [31:0] src_ip, dst_ip, seq, ack, acc;
  logic [15:0] sport, dport, win, plen, psum, csum, dcnt, tcp_len, word;
  logic [7:0] flags, cnt, hlen, slast, bi;
  logic [OW-1:0] opt;
  logic [32*OPT_WORDS_MAX-1:0] options;
  logic [7:0] hb [HB];
  logic [16:0] f1;
  logic [15:0] f2;
  logic run, hdr_end, data_end;
  assign tcp_len = 16'd20 + (16'(opt) << 2) + plen;
  assign hlen = 8'd20 + (8'(opt) << 2);
  assign slast = 8'd16 + (8'(opt) << 1);
  assign bi = 8'((cnt - 8'd6) << 1);
  assign hdr_end = cnt == hlen - 8'd1;
  assign data_end = dcnt == plen - 16'd1;
  assign f1 = 17'(acc[15:0]) + 17'(acc[31:16]);
  assign f2 = f1[15:0] + 16'(f1[16]);
  // Header image; csum is zero while summing, so the same bytes feed both the sum and the output.
  always_comb begin
    hb = '{default: 8'h00};
    hb[0] = sport[15:8];
    hb[1] = sport[7:0];
    hb[2] = dport[15:8];
    hb[3] = dport[7:0];
    for (int k = 0; k < 4; k++) begin
      hb[4 + k] = seq[31 - 8*k -: 8];
      hb[8 + k] = ack[31 - 8*k -: 8];
    end
    hb[12] = {4'd5 + 4'(opt), 4'h0};
    hb[13] = flags;
    hb[14] = win[15:8];
    hb[15] = win[7:0];
    hb[16] = csum[15:8];
    hb[17] = csum[7:0];
    for (int k = 0; k < OPT_WORDS_MAX; k++)
      for (int j = 0; j < 4; j++)
        hb[20 + 4*k + j] = options[32*k + 31 - 8*j -: 8];
  end
  assign word = cnt == 8'd0 ? src_ip[31:16] :
                cnt == 8'd1 ? src_ip[15:0] :
                cnt == 8'd2 ? dst_ip[31:16] :
                cnt == 8'd3 ? dst_ip[15:0] :
                cnt == 8'd4 ? 16'h0006 :
                cnt == 8'd5 ? tcp_len :
                cnt == slast ? psum : {hb[IW'(bi)], hb[IW'(bi + 8'd1)]};
  always_comb begin
    state_n = state;
    o_hdr_ready = 1'b0;
    m_ip_hdr_valid = 1'b0;
    m_ip_payload_axis_tvalid = 1'b0;
    m_ip_payload_axis_tdata = 8'h00;
    m_ip_payload_axis_tlast = 1'b0;
    m_ip_payload_axis_tuser = 1'b0;
    s_axis_data_tready = 1'b0;
    case (state)
      IDLE: begin
        o_hdr_ready = run;
        state_n = i_hdr_valid && run ? SUM : IDLE;
      end
      SUM: state_n = cnt == slast ? FOLD : SUM;
      FOLD: state_n = IPHDR;
      IPHDR: begin
        m_ip_hdr_valid = 1'b1;
        state_n = m_ip_hdr_ready ? HDR : IPHDR;
      end
      HDR: begin
        m_ip_payload_axis_tvalid = 1'b1;
        m_ip_payload_axis_tdata = hb[IW'(cnt)];
        m_ip_payload_axis_tlast = hdr_end && plen == 16'd0;
        if (m_ip_payload_axis_tready && hdr_end) state_n = plen == 16'd0 ? IDLE : DATA;
      end
      DATA: begin
        m_ip_payload_axis_tvalid = s_axis_data_tvalid;
        s_axis_data_tready = m_ip_payload_axis_tready;
        m_ip_payload_axis_tdata = s_axis_data_tdata;
        m_ip_payload_axis_tlast = s_axis_data_tlast || data_end;
        m_ip_payload_axis_tuser = s_axis_data_tlast != data_end;
        if (s_axis_data_tvalid && m_ip_payload_axis_tready && (s_axis_data_tlast || data_end))
          state_n = data_end && !s_axis_data_tlast ? DRAIN : IDLE;
      end
      DRAIN: begin
        s_axis_data_tready = 1'b1;
        state_n = s_axis_data_tvalid && s_axis_data_tlast ? IDLE : DRAIN;
      end
      default: state_n = IDLE;
    endcase
  end
  assign o_packet_done = m_ip_payload_axis_tvalid && m_ip_payload_axis_tready && m_ip_payload_axis_tlast;
  assign o_error = m_ip_payload_axis_tvalid && m_ip_payload_axis_tready && m_ip_payload_axis_tuser;
  assign m_ip_dscp = 6'd0;
  assign m_ip_ecn = 2'd0;
  assign m_ip_length = m_ip_hdr_valid ? tcp_len + 16'd20 : 16'd0;
  assign m_ip_ttl = m_ip_hdr_valid ? 8'(IP_TTL) : 8'd0;
  assign m_ip_protocol = m_ip_hdr_valid ? 8'd6 : 8'd0;
  assign m_ip_source_ip = src_ip;
  assign m_ip_dest_ip = dst_ip;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      run <= 1'b0;
      src_ip <= '0;
      dst_ip <= '0;
      sport <= '0;
      dport <= '0;
      seq <= '0;
      ack <= '0;
      flags <= '0;
      win <= '0;
      opt <= '0;
      options <= '0;
      plen <= '0;
      psum <= '0;
      acc <= '0;
      csum <= '0;
      cnt <= '0;
      dcnt <= '0;
    end else begin
      state <= state_n;
      run <= 1'b1;
      case (state)
        IDLE: if (i_hdr_valid && run) begin
          src_ip <= i_src_ip;
          dst_ip <= i_dst_ip;
          sport <= i_source_port;
          dport <= i_dest_port;
          seq <= i_seq_number;
          ack <= i_ack_number;
          flags <= i_flags;
          win <= i_window_size;
          opt <= i_opt_words > OW'(OPT_WORDS_MAX) ? OW'(OPT_WORDS_MAX) : i_opt_words;
          options <= i_options;
          plen <= i_payload_len;
          psum <= i_payload_sum;
          acc <= '0;
          csum <= '0;
          cnt <= '0;
          dcnt <= '0;
        end
        SUM: begin
          acc <= acc + {16'd0, word};
          cnt <= cnt == slast ? 8'd0 : cnt + 8'd1;
        end
        FOLD: csum <= ~f2;
        HDR: if (m_ip_payload_axis_tready) cnt <= hdr_end ? 8'd0 : cnt + 8'd1;
        DATA: if (s_axis_data_tvalid && m_ip_payload_axis_tready) dcnt <= dcnt + 16'd1;
        default: ;
      endcase
    end
  end
endmodule

// File: doc/tcp_tx_packet_generator.md
Name: tcp_tx_packet_generator

Overview:
Builds complete outbound TCP segments: it emits an IP header request, then the TCP header with variable-length options, then the payload streamed from an AXI-Stream source. It sits between the TCP connection state machine and the IP transmit path. It computes the TCP checksum internally over pseudo-header, header and options, using a payload one's-complement sum supplied upstream. It supports payload forwarding, options and length-mismatch handling, which the header-only generator lacks.

Parameters:
OPT_WORDS_MAX, 2, maximum number of 32-bit TCP option words (0..10)
IP_TTL, 64, TTL placed in the IP header request
OW, $clog2(OPT_WORDS_MAX+1), width of i_opt_words (derived, not overridable)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_hdr_valid  in  1  segment descriptor valid
o_hdr_ready  out  1  descriptor accepted when high with i_hdr_valid
i_src_ip, i_dst_ip  in  32 each  pseudo-header / IP addresses
i_source_port, i_dest_port  in  16 each  TCP ports
i_seq_number, i_ack_number  in  32 each  TCP seq/ack
i_flags  in  8  TCP flags byte
i_window_size  in  16  TCP window
i_opt_words  in  OW  option word count; values above OPT_WORDS_MAX clamp to OPT_WORDS_MAX
i_options  in  32*OPT_WORDS_MAX  option word k at [32k+31:32k], word 0 sent first, MSB first
i_payload_len  in  16  payload bytes
i_payload_sum  in  16  folded one's-complement sum of payload, big-endian 16-bit words, odd byte zero-padded
s_axis_data_tdata/tvalid/tready/tlast  in/in/out/in  8/1/1/1  payload stream
m_ip_hdr_valid  out  1; m_ip_hdr_ready  in  1
m_ip_dscp 6, m_ip_ecn 2, m_ip_length 16, m_ip_ttl 8, m_ip_protocol 8, m_ip_source_ip 32, m_ip_dest_ip 32  out  IP header fields
m_ip_payload_axis_tdata/tvalid/tready/tlast/tuser  out/out/in/out/out  8/1/1/1/1  IP payload stream
o_packet_done  out  1  one-cycle pulse on final output beat handshake
o_error  out  1  one-cycle pulse when a length mismatch is detected

Behaviour:
- All descriptor inputs are latched on the i_hdr_valid & o_hdr_ready cycle. Inputs are don't-care afterwards.
- Reset (async assert, sync release): state IDLE, counters 0, accumulator 0. All valid/ready/tlast/tuser/pulse outputs are 0. Data outputs are 0.
- States:
  - IDLE: o_hdr_ready=1. On accept → SUM.
  - SUM: adds one 16-bit word per cycle into a 32-bit accumulator, in this order: src_ip hi/lo, dst_ip hi/lo, 0x0006, tcp_len, then the 10 header words (checksum field = 0), then 2*opt words, then i_payload_sum. That is 17+2*opt cycles. tcp_len = 20+4*opt+payload_len (16-bit, wraps).
  - FOLD (1 cycle): csum = ~fold(fold(acc)), where fold(x) = x[15:0]+x[31:16]. → IPHDR.
  - IPHDR: m_ip_hdr_valid=1. Fields held stable: dscp=0, ecn=0, ttl=IP_TTL, protocol=6, length=20+tcp_len. Advance to HDR on m_ip_hdr_ready.
  - HDR: tvalid=1. Emits 20+4*opt bytes, counter advances only on tready. Byte 12 = {5+opt, 4'h0}, byte 13 = flags, bytes 16-17 = csum, bytes 18-19 = 0 (urgent), bytes 20+ = options. If payload_len=0, the last header byte carries tlast → IDLE. Otherwise → DATA.
  - DATA: pass-through, combinational: m tvalid = s tvalid, s tready = m tready. Counts accepted bytes. tlast asserts on byte payload_len.
  - Early input tlast (before byte payload_len): forward the byte with tlast=1 and tuser=1, pulse o_error → IDLE.
  - Input has no tlast at byte payload_len: output tlast=1 and tuser=1, pulse o_error → DRAIN.
  - DRAIN: s tready=1, m tvalid=0. Discard bytes through input tlast → IDLE.
- o_packet_done pulses on the handshake of any output tlast beat, errored or not.
- s_axis_data_tready=0 in all states except DATA and DRAIN.
- Minimum IDLE-to-first-payload-beat latency, all readies high: 1+(17+2*opt)+1+1 cycles before HDR, plus 20+4*opt header beats.
- Reset asserted mid-packet aborts immediately. No tlast is emitted, and the next descriptor is accepted normally.

Test Plan:
- SYN, no payload: all addresses/ports/seq/ack/window = 0, flags=0x02, opt=0, len=0 → m_ip_length=0x0028. 20 bytes, byte12=0x50, byte13=0x02, csum bytes AF E3. tlast on byte 19, done pulse.
- Options: as above with opt_words=1, options=0x020405B4 → length=0x002C. 24 bytes, byte12=0x60, csum 98 29, bytes 20-23 = 02 04 05 B4.
- Payload: flags=0, len=3, payload_sum=0x76BC, stream AA BB CC with tlast on CC → length=0x002B, csum 39 26. Output ends AA BB CC, tlast on CC, tuser=0.
- Backpressure: random tready/hdr_ready/s_tvalid on the payload case → identical byte sequence, no drops or duplicates, fields stable while valid.
- Mismatch: len=4 with tlast on 2nd byte → tlast+tuser on byte 2, o_error. Then len=2 with 4 input bytes → tlast+tuser on byte 2, bytes 3-4 drained, next packet correct.
- Reset mid-DATA: assert i_rst_n low → outputs 0 asynchronously. Next SYN test then passes.
